// File: rtl/freelist_ctrl_pkg.sv
// Shared definitions for the physical-register freelist controller:
// machine sizes, index typedefs and the recovery FSM encoding.
package freelist_ctrl_pkg;

   localparam int N                = 3;
   localparam int PHYS_REG_SZ_R10K = 64;
   localparam int ARCH_REG_SZ      = 32;
   localparam int NUM_CKPT_DEF     = 4;

   localparam int PR_IDX_W   = $clog2(PHYS_REG_SZ_R10K);
   localparam int CKPT_IDX_W = $clog2(NUM_CKPT_DEF);

   typedef logic [PR_IDX_W-1:0]   pr_idx_t;
   typedef logic [CKPT_IDX_W-1:0] ckpt_id_t;

   typedef enum logic {
      NORMAL  = 1'b0,
      RECOVER = 1'b1
   } fl_state_e;

endpackage

// File: rtl/freelist_ctrl_onehot_encoder.sv
// One-hot to binary index encoder; index is 0 and valid is low when no bit is set.
module onehot_encoder
   import freelist_ctrl_pkg::*;
#(
   parameter int W     = PHYS_REG_SZ_R10K,
   parameter int IDX_W = PR_IDX_W
) (
   input  logic [W-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // OR-reduction of set positions is exact for a one-hot input.
   always_comb begin
      idx = '0;
      for (int i = 0; i < W; i++) begin
         if (onehot[i]) idx = idx | IDX_W'(i);
      end
   end

   assign valid = |onehot;

endmodule

// File: rtl/freelist_ctrl.sv
// Freelist sequencer: gates dispatch against the free count, tracks PRs allocated
// under each in-flight branch checkpoint and returns them to the freelist on mispredict.
module freelist_ctrl
   import freelist_ctrl_pkg::*;
#(
   parameter  int ALLOC_WIDTH = N,
   parameter  int PR_COUNT    = PHYS_REG_SZ_R10K,
   parameter  int NUM_CKPT    = NUM_CKPT_DEF,
   parameter  int ARCH_REGS   = ARCH_REG_SZ,
   localparam int PIDX_W      = $clog2(PR_COUNT),
   localparam int CID_W       = $clog2(NUM_CKPT),
   localparam int LANE_W      = (ALLOC_WIDTH > 1) ? $clog2(ALLOC_WIDTH) : 1,
   localparam int CNT_W       = $clog2(PR_COUNT + 1)
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [ALLOC_WIDTH-1:0]                disp_req,
   input  logic                                  ckpt_take,
   input  logic [LANE_W-1:0]                     ckpt_lane,
   output logic                                  disp_stall,
   output logic [ALLOC_WIDTH-1:0][PIDX_W-1:0]    disp_pr_idx,
   output logic [ALLOC_WIDTH-1:0]                disp_pr_valid,
   output logic [CID_W-1:0]                      ckpt_id,
   input  logic [ALLOC_WIDTH-1:0]                retire_valid,
   input  logic [ALLOC_WIDTH-1:0][PIDX_W-1:0]    retire_pr_idx,
   input  logic                                  resolve_valid,
   input  logic [CID_W-1:0]                      resolve_id,
   input  logic                                  recover_valid,
   input  logic [CID_W-1:0]                      recover_id,
   output logic [ALLOC_WIDTH-1:0]                fl_alloc_req,
   input  logic [ALLOC_WIDTH-1:0][PR_COUNT-1:0]  fl_granted_regs,
   output logic [PR_COUNT-1:0]                   fl_free_mask,
   output fl_state_e                             dbg_state,
   output logic [CNT_W-1:0]                      dbg_free_cnt,
   output logic [CID_W:0]                        dbg_ckpt_cnt
);

   localparam logic [CID_W:0] PTR_ONE = (CID_W + 1)'(1);

   fl_state_e                          state, state_n;
   logic                               in_recover;
   logic [CNT_W-1:0]                   free_cnt, free_cnt_n, free_pop, grant_pop;
   logic [CNT_W:0]                     cnt_up, grant_ext;
   logic [CID_W:0]                     head, tail, head_n, tail_n, ckpt_cnt;
   logic [CID_W-1:0]                   head_idx, tail_idx, rec_id;
   logic [NUM_CKPT-1:0][PR_COUNT-1:0]  ckpt_mask, mask_n;
   logic [NUM_CKPT-1:0]                dead, dead_n, active;
   logic [NUM_CKPT-1:0][CID_W-1:0]     slot_age;
   logic [ALLOC_WIDTH-1:0]             grant_lanes;
   logic [PR_COUNT-1:0]                grant_bits, young_bits;
   logic                               take, resolve_ok, recover_ok;

   function automatic logic [CNT_W-1:0] popcnt_pr(input logic [PR_COUNT-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < PR_COUNT; i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] popcnt_lane(input logic [ALLOC_WIDTH-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < ALLOC_WIDTH; i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

   for (genvar i = 0; i < ALLOC_WIDTH; i++) begin : g_enc
      onehot_encoder #(.W(PR_COUNT), .IDX_W(PIDX_W)) u_enc (
         .onehot (fl_granted_regs[i]),
         .idx    (disp_pr_idx[i]),
         .valid  (disp_pr_valid[i])
      );
   end

   // ---------------- recovery FSM ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= NORMAL;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         NORMAL:  if (recover_valid) state_n = RECOVER;
         RECOVER: state_n = NORMAL;
         default: state_n = NORMAL;
      endcase
   end

   always_comb begin
      in_recover = (state == RECOVER);
   end

   // ---------------- dispatch gating ----------------
   assign head_idx = head[CID_W-1:0];
   assign tail_idx = tail[CID_W-1:0];
   assign ckpt_cnt = tail - head;

   assign disp_stall = recover_valid | in_recover
                     | (popcnt_lane(disp_req) > free_cnt)
                     | (ckpt_take & (ckpt_cnt == (CID_W + 1)'(NUM_CKPT)));
   assign fl_alloc_req = disp_stall ? '0 : disp_req;
   assign grant_lanes  = fl_alloc_req & disp_pr_valid;
   assign take         = ckpt_take & ~disp_stall;
   assign ckpt_id      = tail_idx;

   always_comb begin
      grant_bits = '0;
      young_bits = '0;
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
         if (grant_lanes[i]) begin
            grant_bits = grant_bits | fl_granted_regs[i];
            if (i > int'(ckpt_lane)) young_bits = young_bits | fl_granted_regs[i];
         end
      end
   end

   // Age is distance from head; it orders slots in the circular stack.
   always_comb begin
      slot_age = '0;
      active   = '0;
      for (int s = 0; s < NUM_CKPT; s++) begin
         slot_age[s] = CID_W'(s) - head_idx;
         active[s]   = ({1'b0, slot_age[s]} < ckpt_cnt);
      end
   end

   // A resolve is dropped when the same or an older branch is being squashed.
   assign resolve_ok = resolve_valid && active[resolve_id] && !dead[resolve_id]
                     && !(recover_valid && (slot_age[resolve_id] >= slot_age[recover_id]))
                     && !(in_recover && (slot_age[resolve_id] >= slot_age[rec_id]));
   assign recover_ok = in_recover && active[rec_id] && !dead[rec_id];

   // ---------------- checkpoint stack next state ----------------
   always_comb begin
      mask_n = ckpt_mask;
      dead_n = dead;
      head_n = head;
      tail_n = tail;
      for (int s = 0; s < NUM_CKPT; s++) begin
         if (active[s] && !dead[s]) mask_n[s] = mask_n[s] | grant_bits;
      end
      if (take) begin
         mask_n[tail_idx] = young_bits;
         dead_n[tail_idx] = 1'b0;
         tail_n           = tail + PTR_ONE;
      end
      if (resolve_ok) begin
         mask_n[resolve_id] = '0;
         if (resolve_id == head_idx) head_n = head + PTR_ONE;
         else                        dead_n[resolve_id] = 1'b1;
      end
      if (recover_ok) begin
         tail_n = head + {1'b0, slot_age[rec_id]};
         for (int s = 0; s < NUM_CKPT; s++) begin
            if (active[s] && (slot_age[s] >= slot_age[rec_id])) begin
               mask_n[s] = '0;
               dead_n[s] = 1'b0;
            end
         end
      end
      for (int i = 0; i < NUM_CKPT; i++) begin
         if ((head_n != tail_n) && dead_n[head_n[CID_W-1:0]]) begin
            dead_n[head_n[CID_W-1:0]] = 1'b0;
            head_n = head_n + PTR_ONE;
         end
      end
   end

   // ---------------- free mask and free count ----------------
   always_comb begin
      fl_free_mask = '0;
      if (in_recover) fl_free_mask = ckpt_mask[rec_id];
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
         if (retire_valid[i]) fl_free_mask[retire_pr_idx[i]] = 1'b1;
      end
      if (reset) fl_free_mask = '0;
   end

   assign free_pop   = popcnt_pr(fl_free_mask);
   assign grant_pop  = popcnt_lane(grant_lanes);
   assign cnt_up     = {1'b0, free_cnt} + {1'b0, free_pop};
   assign grant_ext  = {1'b0, grant_pop};
   assign free_cnt_n = CNT_W'(cnt_up - grant_ext);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         free_cnt  <= CNT_W'(PR_COUNT - ARCH_REGS);
         ckpt_mask <= '0;
         dead      <= '0;
         head      <= '0;
         tail      <= '0;
         rec_id    <= '0;
      end else begin
         free_cnt  <= free_cnt_n;
         ckpt_mask <= mask_n;
         dead      <= dead_n;
         head      <= head_n;
         tail      <= tail_n;
         if (recover_valid && (state == NORMAL)) rec_id <= recover_id;
      end
   end

   always @(posedge clock) begin
      if (!reset) begin
         assert (!(recover_valid && in_recover));
         assert ((cnt_up >= grant_ext) && ((cnt_up - grant_ext) <= (CNT_W + 1)'(PR_COUNT)));
      end
   end

   assign dbg_state    = state;
   assign dbg_free_cnt = free_cnt;
   assign dbg_ckpt_cnt = ckpt_cnt;

endmodule

// File: tb/tb_freelist_ctrl.sv
// Directed bench for freelist_ctrl: a lowest-index-first freelist model feeds grants,
// a vector table covers dispatch/retire, hand sequences cover checkpoint corners.
module tb_freelist_ctrl;
   import freelist_ctrl_pkg::*;

   localparam int AW   = N;
   localparam int PRC  = PHYS_REG_SZ_R10K;
   localparam int PW   = PR_IDX_W;
   localparam int CW   = CKPT_IDX_W;
   localparam int LW   = $clog2(AW);
   localparam int CNTW = $clog2(PRC + 1);
   localparam int NV   = 17;

   logic                        clock, reset;
   logic [AW-1:0]               disp_req;
   logic                        ckpt_take;
   logic [LW-1:0]               ckpt_lane;
   logic                        disp_stall;
   logic [AW-1:0][PW-1:0]       disp_pr_idx;
   logic [AW-1:0]               disp_pr_valid;
   logic [CW-1:0]               ckpt_id;
   logic [AW-1:0]               retire_valid;
   logic [AW-1:0][PW-1:0]       retire_pr_idx;
   logic                        resolve_valid;
   logic [CW-1:0]               resolve_id;
   logic                        recover_valid;
   logic [CW-1:0]               recover_id;
   logic [AW-1:0]               fl_alloc_req;
   logic [AW-1:0][PRC-1:0]      fl_granted_regs;
   logic [PRC-1:0]              fl_free_mask;
   fl_state_e                   dbg_state;
   logic [CNTW-1:0]             dbg_free_cnt;
   logic [CW:0]                 dbg_ckpt_cnt;

   freelist_ctrl dut (
      .clock(clock), .reset(reset), .disp_req(disp_req), .ckpt_take(ckpt_take),
      .ckpt_lane(ckpt_lane), .disp_stall(disp_stall), .disp_pr_idx(disp_pr_idx),
      .disp_pr_valid(disp_pr_valid), .ckpt_id(ckpt_id), .retire_valid(retire_valid),
      .retire_pr_idx(retire_pr_idx), .resolve_valid(resolve_valid), .resolve_id(resolve_id),
      .recover_valid(recover_valid), .recover_id(recover_id), .fl_alloc_req(fl_alloc_req),
      .fl_granted_regs(fl_granted_regs), .fl_free_mask(fl_free_mask),
      .dbg_state(dbg_state), .dbg_free_cnt(dbg_free_cnt), .dbg_ckpt_cnt(dbg_ckpt_cnt)
   );

   typedef struct {
      logic [AW-1:0]         req;
      logic [AW-1:0]         ret_v;
      logic [AW-1:0][PW-1:0] ret;
      logic [CNTW-1:0]       exp_cnt;
      logic                  exp_stall;
      logic [AW-1:0]         exp_alloc;
      logic [AW-1:0]         exp_valid;
      logic [AW-1:0][PW-1:0] exp_idx;
      logic [PRC-1:0]        exp_mask;
   } vec_t;

   vec_t           vecs[NV];
   int             total, bad;
   logic [PRC-1:0] model_free;
   logic [CW-1:0]  exp_q[$];

   // ---------------- clock ----------------
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [PRC-1:0] pr_bit(input int a);
      logic [PRC-1:0] m;
      m = '0;
      m[a] = 1'b1;
      return m;
   endfunction

   task automatic set_vec(input int k, input logic [AW-1:0] req, input logic [AW-1:0] rv,
                          input int r0, input int r1, input int r2, input int cnt,
                          input logic stall, input logic [AW-1:0] alloc, input logic [AW-1:0] valid,
                          input int e0, input int e1, input int e2, input logic [PRC-1:0] mask);
      vecs[k].req       = req;
      vecs[k].ret_v     = rv;
      vecs[k].ret[0]    = PW'(r0);
      vecs[k].ret[1]    = PW'(r1);
      vecs[k].ret[2]    = PW'(r2);
      vecs[k].exp_cnt   = CNTW'(cnt);
      vecs[k].exp_stall = stall;
      vecs[k].exp_alloc = alloc;
      vecs[k].exp_valid = valid;
      vecs[k].exp_idx[0] = PW'(e0);
      vecs[k].exp_idx[1] = PW'(e1);
      vecs[k].exp_idx[2] = PW'(e2);
      vecs[k].exp_mask  = mask;
   endtask

   // ---------------- drivers ----------------
   task automatic idle_inputs();
      disp_req = '0; ckpt_take = 1'b0; ckpt_lane = '0;
      retire_valid = '0; retire_pr_idx = '0;
      resolve_valid = 1'b0; resolve_id = '0;
      recover_valid = 1'b0; recover_id = '0;
      fl_granted_regs = '0;
   endtask

   // Freelist model: each requesting lane gets the lowest free PR not yet handed out.
   task automatic make_grants();
      logic [PRC-1:0] avail;
      avail = model_free;
      fl_granted_regs = '0;
      for (int i = 0; i < AW; i++) begin
         if (fl_alloc_req[i]) begin
            for (int b = 0; b < PRC; b++) begin
               if (avail[b]) begin
                  fl_granted_regs[i][b] = 1'b1;
                  avail[b] = 1'b0;
                  break;
               end
            end
         end
      end
   endtask

   task automatic settle();
      #1 make_grants();
      #1;
   endtask

   task automatic tick();
      logic [PRC-1:0] fm, gb;
      fm = fl_free_mask;
      gb = '0;
      for (int i = 0; i < AW; i++) gb = gb | fl_granted_regs[i];
      @(posedge clock);
      model_free = (model_free & ~gb) | fm;
      @(negedge clock);
      idle_inputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      model_free = '0;
      for (int b = ARCH_REG_SZ; b < PRC; b++) model_free[b] = 1'b1;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   // ---------------- test ----------------
   initial begin
      total = 0;
      bad   = 0;
      for (int k = 0; k < 10; k++)
         set_vec(k, 3'b111, 3'b000, 0, 0, 0, 32 - 3 * k, 1'b0, 3'b111, 3'b111,
                 32 + 3 * k, 33 + 3 * k, 34 + 3 * k, '0);
      set_vec(10, 3'b111, 3'b000, 0, 0, 0, 2, 1'b1, 3'b000, 3'b000, 0, 0, 0, '0);
      set_vec(11, 3'b111, 3'b001, 5, 0, 0, 2, 1'b1, 3'b000, 3'b000, 0, 0, 0, pr_bit(5));
      set_vec(12, 3'b111, 3'b000, 0, 0, 0, 3, 1'b0, 3'b111, 3'b111, 5, 62, 63, '0);
      set_vec(13, 3'b001, 3'b000, 0, 0, 0, 0, 1'b1, 3'b000, 3'b000, 0, 0, 0, '0);
      set_vec(14, 3'b000, 3'b111, 10, 10, 11, 0, 1'b0, 3'b000, 3'b000, 0, 0, 0,
              pr_bit(10) | pr_bit(11));
      set_vec(15, 3'b000, 3'b111, 32, 33, 34, 2, 1'b0, 3'b000, 3'b000, 0, 0, 0,
              pr_bit(32) | pr_bit(33) | pr_bit(34));
      set_vec(16, 3'b110, 3'b000, 0, 0, 0, 5, 1'b0, 3'b110, 3'b110, 0, 10, 11, '0);

      do_reset();
      settle();
      chk("rst_cnt", 64'(dbg_free_cnt), 64'(32));
      chk("rst_state", 64'(dbg_state), 64'(NORMAL));
      chk("rst_ckpt_cnt", 64'(dbg_ckpt_cnt), 64'(0));
      chk("rst_mask", 64'(fl_free_mask), 64'(0));
      chk("rst_stall", 64'(disp_stall), 64'(0));
      tick();

      // Dispatch / retire table.
      for (int k = 0; k < NV; k++) begin
         disp_req      = vecs[k].req;
         retire_valid  = vecs[k].ret_v;
         retire_pr_idx = vecs[k].ret;
         settle();
         chk($sformatf("v%0d_cnt", k), 64'(dbg_free_cnt), 64'(vecs[k].exp_cnt));
         chk($sformatf("v%0d_stall", k), 64'(disp_stall), 64'(vecs[k].exp_stall));
         chk($sformatf("v%0d_alloc", k), 64'(fl_alloc_req), 64'(vecs[k].exp_alloc));
         chk($sformatf("v%0d_valid", k), 64'(disp_pr_valid), 64'(vecs[k].exp_valid));
         for (int i = 0; i < AW; i++)
            chk($sformatf("v%0d_idx%0d", k, i), 64'(disp_pr_idx[i]), 64'(vecs[k].exp_idx[i]));
         chk($sformatf("v%0d_mask", k), 64'(fl_free_mask), 64'(vecs[k].exp_mask));
         tick();
      end
      chk("tbl_end_cnt", 64'(dbg_free_cnt), 64'(3));

      // Branch on lane 0 then mispredict: lanes 1,2 grants come back.
      do_reset();
      disp_req = 3'b111; ckpt_take = 1'b1; ckpt_lane = 2'd0;
      settle();
      chk("a_id", 64'(ckpt_id), 64'(0));
      chk("a_stall", 64'(disp_stall), 64'(0));
      chk("a_idx0", 64'(disp_pr_idx[0]), 64'(32));
      tick();
      disp_req = 3'b111; recover_valid = 1'b1; recover_id = 2'd0;
      settle();
      chk("a_rcv_stall", 64'(disp_stall), 64'(1));
      chk("a_rcv_alloc", 64'(fl_alloc_req), 64'(0));
      tick();
      disp_req = 3'b111;
      settle();
      chk("a_state_rec", 64'(dbg_state), 64'(RECOVER));
      chk("a_free_mask", 64'(fl_free_mask), 64'(pr_bit(33) | pr_bit(34)));
      chk("a_rec_stall", 64'(disp_stall), 64'(1));
      chk("a_rec_cnt", 64'(dbg_free_cnt), 64'(29));
      tick();
      disp_req = 3'b001; ckpt_take = 1'b1; ckpt_lane = 2'd0;
      settle();
      chk("a_post_cnt", 64'(dbg_free_cnt), 64'(31));
      chk("a_post_state", 64'(dbg_state), 64'(NORMAL));
      chk("a_post_mask", 64'(fl_free_mask), 64'(0));
      chk("a_post_id", 64'(ckpt_id), 64'(0));
      chk("a_post_idx0", 64'(disp_pr_idx[0]), 64'(33));
      tick();

      // Fill the checkpoint stack, stall, wrap, and head skipping a dead slot.
      do_reset();
      for (int i = 0; i < 4; i++) exp_q.push_back(CW'(i));
      for (int i = 0; i < 4; i++) begin
         ckpt_take = 1'b1;
         settle();
         chk($sformatf("b_take%0d_stall", i), 64'(disp_stall), 64'(0));
         chk($sformatf("b_take%0d_id", i), 64'(ckpt_id), 64'(exp_q.pop_front()));
         tick();
      end
      ckpt_take = 1'b1; resolve_valid = 1'b1; resolve_id = 2'd0;
      settle();
      chk("b_full_cnt", 64'(dbg_ckpt_cnt), 64'(4));
      chk("b_full_stall", 64'(disp_stall), 64'(1));
      tick();
      ckpt_take = 1'b1;
      settle();
      chk("b_wrap_stall", 64'(disp_stall), 64'(0));
      chk("b_wrap_id", 64'(ckpt_id), 64'(0));
      tick();
      resolve_valid = 1'b1; resolve_id = 2'd2;
      settle();
      tick();
      settle();
      chk("b_dead_cnt", 64'(dbg_ckpt_cnt), 64'(4));
      resolve_valid = 1'b1; resolve_id = 2'd1;
      tick();
      settle();
      chk("b_skip_cnt", 64'(dbg_ckpt_cnt), 64'(2));
      tick();

      // Recover an older branch: younger branch dropped, its later resolves ignored.
      do_reset();
      disp_req = 3'b111; ckpt_take = 1'b1; ckpt_lane = 2'd2;
      settle();
      chk("c_id_a", 64'(ckpt_id), 64'(0));
      tick();
      disp_req = 3'b001; ckpt_take = 1'b1; ckpt_lane = 2'd0;
      settle();
      chk("c_id_b", 64'(ckpt_id), 64'(1));
      tick();
      disp_req = 3'b001;
      settle();
      chk("c_idx_late", 64'(disp_pr_idx[0]), 64'(36));
      tick();
      recover_valid = 1'b1; recover_id = 2'd0;
      settle();
      tick();
      resolve_valid = 1'b1; resolve_id = 2'd1;
      retire_valid = 3'b001; retire_pr_idx[0] = PW'(3);
      settle();
      chk("c_free_mask", 64'(fl_free_mask), 64'(pr_bit(3) | pr_bit(35) | pr_bit(36)));
      tick();
      resolve_valid = 1'b1; resolve_id = 2'd1;
      settle();
      chk("c_cnt", 64'(dbg_free_cnt), 64'(30));
      chk("c_ckpt_cnt", 64'(dbg_ckpt_cnt), 64'(0));
      tick();
      ckpt_take = 1'b1;
      settle();
      chk("c_ckpt_cnt2", 64'(dbg_ckpt_cnt), 64'(0));
      chk("c_next_id", 64'(ckpt_id), 64'(0));
      tick();

      // Reset asserted in the middle of the recovery cycle.
      do_reset();
      disp_req = 3'b111; ckpt_take = 1'b1; ckpt_lane = 2'd0;
      settle();
      tick();
      recover_valid = 1'b1; recover_id = 2'd0;
      settle();
      tick();
      retire_valid = 3'b001; retire_pr_idx[0] = PW'(7);
      settle();
      chk("d_state_rec", 64'(dbg_state), 64'(RECOVER));
      chk("d_mask_pre", 64'(fl_free_mask), 64'(pr_bit(7) | pr_bit(33) | pr_bit(34)));
      reset = 1'b1;
      #1;
      chk("d_mask_rst", 64'(fl_free_mask), 64'(0));
      chk("d_cnt_rst", 64'(dbg_free_cnt), 64'(32));
      chk("d_state_rst", 64'(dbg_state), 64'(NORMAL));
      chk("d_ckpt_rst", 64'(dbg_ckpt_cnt), 64'(0));
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
